// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic wants_high(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake between the execute stage (master) and the multiply/divide unit (slave).
interface muldiv_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_q;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_q
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_q
  );
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit, trial-subtract.
module muldiv_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The partial remainder is always below the divisor, so the top diff bit is a clean borrow flag.
  assign shifted   = {rem, quot[XLEN-1]};
  assign diff      = shifted - {1'b0, divisor};
  assign rem_next  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quot_next = {quot[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, one op in flight.
// Define MULDIV_FAST_MUL_EN to compute all multiplies with a single-cycle hardware multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int              CNT_W = $clog2(XLEN);
  localparam logic [1:0]      IDLE  = ST_IDLE;
  localparam logic [1:0]      BUSY  = ST_BUSY;
  localparam logic [1:0]      DONE  = ST_DONE;
  localparam logic [XLEN-1:0] MIN   = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   result;
  muldiv_op_e        op_r;
  logic              q_neg;
  logic              r_neg;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;

  muldiv_op_e      op_in;
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] shortcut_q;

  assign op_in       = muldiv_op_e'(bus.in_op);
  assign accept      = bus.in_valid && bus.in_ready && !bus.flush;
  assign a_neg       = is_signed_a(op_in) && bus.in_a[XLEN-1];
  assign b_neg       = is_signed_b(op_in) && bus.in_b[XLEN-1];
  assign a_mag       = a_neg ? -bus.in_a : bus.in_a;
  assign b_mag       = b_neg ? -bus.in_b : bus.in_b;
  assign div_by_zero = is_div(op_in) && (bus.in_b == '0);
  assign div_ovf     = is_div(op_in) && is_signed_b(op_in) && (bus.in_a == MIN) && (bus.in_b == '1);
  assign shortcut_q  = div_by_zero ? (is_rem(op_in) ? bus.in_a : '1)
                                   : (is_rem(op_in) ? '0 : MIN);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic        [XLEN-1:0]   fast_q;

  assign fast_a    = {{XLEN{is_signed_a(op_in) && bus.in_a[XLEN-1]}}, bus.in_a};
  assign fast_b    = {{XLEN{is_signed_b(op_in) && bus.in_b[XLEN-1]}}, bus.in_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_q    = wants_high(op_in) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
`endif

  // Shift-add multiply: add the multiplicand into the high half when the low multiplier bit is set.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fix;
  logic [XLEN-1:0]   rem_next, quot_next, div_q, div_r, final_q;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  muldiv_divstep #(.XLEN(XLEN)) u_divstep (
    .rem       (acc[2*XLEN-1:XLEN]),
    .quot      (acc[XLEN-1:0]),
    .divisor   (opnd),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Signs are applied only to the last step's output, so the accumulator stays a pure magnitude.
  assign prod_fix = q_neg ? -mul_next : mul_next;
  assign div_q    = q_neg ? -quot_next : quot_next;
  assign div_r    = r_neg ? -rem_next : rem_next;
  assign final_q  = is_div(op_r)     ? (is_rem(op_r) ? div_r : div_q)
                  : wants_high(op_r) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_q     = result;

  // NOTE: state registers use non-blocking assignments so every always_ff reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (div_by_zero || div_ovf) begin
            result <= shortcut_q;
            state  <= DONE;
            cnt    <= '0;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div(op_in)) begin
            result <= fast_q;
            state  <= DONE;
            cnt    <= '0;
          end
`endif
          else begin
            state <= BUSY;
            cnt   <= CNT_W'(XLEN - 1);
          end
        end
        BUSY: if (cnt == '0) begin
          result <= final_q;
          state  <= DONE;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are deliberately left unreset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= op_in;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      acc   <= {{XLEN{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
      opnd  <= is_div(op_in) ? b_mag : a_mag;
    end else if (state == BUSY) begin
      acc <= is_div(op_r) ? {rem_next, quot_next} : mul_next;
    end
  end
endmodule
